// File: rtl/signed_display_driver_if.sv
// signed_display_driver_if: value handshake and status bundle for the signed display driver
interface signed_display_driver_if #(parameter int WIDTH = 16);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             done;
  logic             sign;
  logic             overflow;
  modport master (output valid, data, input ready, done, sign, overflow);
  modport slave (input valid, data, output ready, done, sign, overflow);
endinterface

// File: rtl/signed_display_driver.sv
// signed_display_driver: signed value -> sign-magnitude -> sequential BCD -> multiplexed 7-segment display
module signed_display_driver #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_ZEROS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  signed_display_driver_if.slave   bus,
  output logic [6:0]               segments,
  output logic [DIGITS-1:0]        display_select
);
  localparam int NB = (WIDTH + 2) / 3;
  localparam int BW = 4 * NB;
  localparam int DW = 4 * DIGITS;
  localparam int EW = BW > DW ? BW : DW;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_mag;
  logic [BW-1:0]    r_bcd, w_adj;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_in, r_sign, r_ovf, w_ovf, w_blank;
  logic [DW-1:0]    r_disp;
  logic [EW-1:0]    w_ext;
  logic [RW-1:0]    r_rcnt;
  logic [IW-1:0]    r_idx;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE    ? (bus.valid ? CONVERT : IDLE) :
             r_state == CONVERT ? (r_cnt == CW'(1) ? DONE : CONVERT) : IDLE;
  end
  assign bus.ready    = r_state == IDLE;
  assign bus.done     = r_state == DONE;
  assign bus.sign     = r_sign;
  assign bus.overflow = r_ovf;
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NB; i++)
      w_adj[4*i +: 4] = r_bcd[4*i +: 4] >= 4'd5 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
  end
  assign w_ext = EW'(r_bcd);
  generate
    if (EW > DW) begin : g_ovf
      assign w_ovf = |w_ext[EW-1:DW];
    end else begin : g_no_ovf
      assign w_ovf = 1'b0;
    end
  endgenerate
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_mag     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_sign_in <= 1'b0;
      r_disp    <= '0;
      r_sign    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.valid) begin
        r_sign_in <= bus.data[WIDTH-1];
        r_mag     <= bus.data[WIDTH-1] ? -bus.data : bus.data;
        r_bcd     <= '0;
        r_cnt     <= CW'(WIDTH);
      end
      if (r_state == CONVERT) begin
        {r_bcd, r_mag} <= {w_adj, r_mag} << 1;
        r_cnt          <= r_cnt - CW'(1);
      end
      if (r_state == DONE) begin
        r_disp <= w_ext[DW-1:0];
        r_sign <= r_sign_in;
        r_ovf  <= w_ovf;
      end
    end
  // A digit is a leading zero exactly when it and everything above it is zero.
  assign w_nib   = r_disp[{r_idx, 2'b00} +: 4];
  assign w_blank = BLANK_ZEROS != 0 && r_idx != '0 && (r_disp >> {r_idx, 2'b00}) == '0;
  assign w_seg   = r_ovf ? 7'b0111111 : w_blank ? 7'b1111111 : seg7(w_nib);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_rcnt         <= '0;
      r_idx          <= '0;
      segments       <= 7'h7F;
      display_select <= '1;
    end else if (r_rcnt == RW'(REFRESH_DIV - 1)) begin
      r_rcnt         <= '0;
      r_idx          <= r_idx == IW'(DIGITS - 1) ? '0 : r_idx + IW'(1);
      segments       <= w_seg;
      display_select <= ~(DIGITS'(1) << r_idx);
    end else begin
      r_rcnt <= r_rcnt + RW'(1);
    end
endmodule
